// File: rtl/graph_neighbor_fetch.sv
// Walks a zero-terminated adjacency list, optionally filters visited neighbours,
// and streams one packet per surviving neighbour: its address followed by DIM position words.
module graph_neighbor_fetch #(
    parameter int DIM            = 2,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int OUT_DEPTH      = 8,
    parameter int MAX_DEG        = 64,
    parameter int FILTER_VISITED = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,

    input  logic [ADDR_W-1:0] v_addr_in,
    input  logic              valid_in,
    output logic              ready_out,

    output logic              adj_req_valid_out,
    output logic [ADDR_W-1:0] adj_req_addr_out,
    input  logic              adj_req_ready_in,
    input  logic              adj_resp_valid_in,
    input  logic [DATA_W-1:0] adj_resp_data_in,

    output logic              pos_req_valid_out,
    output logic [ADDR_W-1:0] pos_req_addr_out,
    input  logic              pos_req_ready_in,
    input  logic              pos_resp_valid_in,
    input  logic [DATA_W-1:0] pos_resp_data_in,

    output logic              vis_req_valid_out,
    output logic [ADDR_W-1:0] vis_req_addr_out,
    input  logic              vis_req_ready_in,
    input  logic              vis_resp_valid_in,
    input  logic              vis_resp_hit_in,
    output logic              vis_set_out,
    output logic [ADDR_W-1:0] vis_set_addr_out,

    output logic [DATA_W-1:0] out_data_out,
    output logic              out_first_out,
    output logic              out_last_out,
    output logic              out_valid_out,
    input  logic              out_ready_in,

    output logic              done_out,
    output logic [CNT_W-1:0]  emitted_count_out,
    output logic [CNT_W-1:0]  skipped_count_out
);

    localparam int KW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int EW = DATA_W + 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADJ_REQ,
        S_ADJ_WAIT,
        S_VIS_REQ,
        S_VIS_WAIT,
        S_SPACE,
        S_POS_REQ,
        S_POS_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] nbr;
    logic [KW-1:0]     k;
    logic [31:0]       scanned;
    logic              at_limit;

    logic [EW-1:0]     fifo_mem [OUT_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     free_slots;
    logic              space_ok;
    logic              push;
    logic              pop;
    logic [EW-1:0]     push_word;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign at_limit   = (MAX_DEG != 0) && (scanned == 32'(MAX_DEG));
    // Free count ignores a same-cycle pop, so a whole packet always fits once started.
    assign free_slots = CW'(OUT_DEPTH) - count;
    assign space_ok   = free_slots >= CW'(DIM + 1);
    assign ready_out  = (state == S_IDLE);

    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (state == S_SPACE && space_ok) begin
            push      = 1'b1;
            push_word = {DATA_W'(nbr), 1'b1, 1'b0};
        end else if (state == S_POS_WAIT && pos_resp_valid_in) begin
            push      = 1'b1;
            push_word = {pos_resp_data_in, 1'b0, (k == KW'(DIM - 1))};
        end
    end

    assign pop           = (count != '0) && out_ready_in;
    assign out_valid_out = (count != '0);
    assign {out_data_out, out_first_out, out_last_out} = fifo_mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Request valids are raised on the first cycle in a *_REQ state and dropped on handshake;
    // responses are only consumed in the matching *_WAIT state, so stray ones are ignored.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= S_IDLE;
            ptr               <= '0;
            nbr               <= '0;
            k                 <= '0;
            scanned           <= '0;
            adj_req_valid_out <= 1'b0;
            adj_req_addr_out  <= '0;
            pos_req_valid_out <= 1'b0;
            pos_req_addr_out  <= '0;
            vis_req_valid_out <= 1'b0;
            vis_req_addr_out  <= '0;
            vis_set_out       <= 1'b0;
            vis_set_addr_out  <= '0;
            done_out          <= 1'b0;
            emitted_count_out <= '0;
            skipped_count_out <= '0;
        end else begin
            vis_set_out <= 1'b0;
            done_out    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_in) begin
                        ptr               <= v_addr_in + ADDR_W'(DIM + 1);
                        scanned           <= '0;
                        emitted_count_out <= '0;
                        skipped_count_out <= '0;
                        state             <= S_ADJ_REQ;
                    end
                end
                S_ADJ_REQ: begin
                    if (!adj_req_valid_out) begin
                        adj_req_valid_out <= 1'b1;
                        adj_req_addr_out  <= ptr;
                    end else if (adj_req_ready_in) begin
                        adj_req_valid_out <= 1'b0;
                        state             <= S_ADJ_WAIT;
                    end
                end
                S_ADJ_WAIT: begin
                    if (adj_resp_valid_in) begin
                        if (adj_resp_data_in == '0) begin
                            state <= S_DONE;
                        end else begin
                            nbr     <= adj_resp_data_in[ADDR_W-1:0];
                            ptr     <= ptr + ADDR_W'(1);
                            scanned <= scanned + 32'd1;
                            if (FILTER_VISITED != 0) begin
                                state <= S_VIS_REQ;
                            end else begin
                                state <= S_SPACE;
                            end
                        end
                    end
                end
                S_VIS_REQ: begin
                    if (!vis_req_valid_out) begin
                        vis_req_valid_out <= 1'b1;
                        vis_req_addr_out  <= nbr;
                    end else if (vis_req_ready_in) begin
                        vis_req_valid_out <= 1'b0;
                        state             <= S_VIS_WAIT;
                    end
                end
                S_VIS_WAIT: begin
                    if (vis_resp_valid_in) begin
                        if (vis_resp_hit_in) begin
                            skipped_count_out <= sat_inc(skipped_count_out);
                            if (at_limit) begin
                                state <= S_DONE;
                            end else begin
                                state <= S_ADJ_REQ;
                            end
                        end else begin
                            state <= S_SPACE;
                        end
                    end
                end
                S_SPACE: begin
                    if (space_ok) begin
                        vis_set_out      <= 1'b1;
                        vis_set_addr_out <= nbr;
                        k                <= '0;
                        state            <= S_POS_REQ;
                    end
                end
                S_POS_REQ: begin
                    if (!pos_req_valid_out) begin
                        pos_req_valid_out <= 1'b1;
                        pos_req_addr_out  <= nbr + ADDR_W'(1) + ADDR_W'(k);
                    end else if (pos_req_ready_in) begin
                        pos_req_valid_out <= 1'b0;
                        state             <= S_POS_WAIT;
                    end
                end
                S_POS_WAIT: begin
                    if (pos_resp_valid_in) begin
                        if (k != KW'(DIM - 1)) begin
                            k     <= k + KW'(1);
                            state <= S_POS_REQ;
                        end else begin
                            emitted_count_out <= sat_inc(emitted_count_out);
                            if (at_limit) begin
                                state <= S_DONE;
                            end else begin
                                state <= S_ADJ_REQ;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_out <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_graph_neighbor_fetch.sv
// Scoreboard bench for graph_neighbor_fetch: memory/visited responders, a list-walking
// reference model, and decoupled monitors for the output stream, vis_set and done.
module tb_graph_neighbor_fetch;

    localparam int DIM       = 2;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int OUT_DEPTH = 4;
    localparam int MAX_DEG   = 3;
    localparam int CNT_W     = 16;
    localparam int MEMSZ     = 1024;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic [ADDR_W-1:0] v_addr_in = '0;
    logic              valid_in = 1'b0;
    logic              ready_out;
    logic              adj_req_valid_out;
    logic [ADDR_W-1:0] adj_req_addr_out;
    logic              adj_req_ready_in = 1'b0;
    logic              adj_resp_valid_in = 1'b0;
    logic [DATA_W-1:0] adj_resp_data_in = '0;
    logic              pos_req_valid_out;
    logic [ADDR_W-1:0] pos_req_addr_out;
    logic              pos_req_ready_in = 1'b0;
    logic              pos_resp_valid_in = 1'b0;
    logic [DATA_W-1:0] pos_resp_data_in = '0;
    logic              vis_req_valid_out;
    logic [ADDR_W-1:0] vis_req_addr_out;
    logic              vis_req_ready_in = 1'b0;
    logic              vis_resp_valid_in = 1'b0;
    logic              vis_resp_hit_in = 1'b0;
    logic              vis_set_out;
    logic [ADDR_W-1:0] vis_set_addr_out;
    logic [DATA_W-1:0] out_data_out;
    logic              out_first_out;
    logic              out_last_out;
    logic              out_valid_out;
    logic              out_ready_in = 1'b0;
    logic              done_out;
    logic [CNT_W-1:0]  emitted_count_out;
    logic [CNT_W-1:0]  skipped_count_out;

    graph_neighbor_fetch #(
        .DIM(DIM), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_DEPTH(OUT_DEPTH),
        .MAX_DEG(MAX_DEG), .FILTER_VISITED(1), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .v_addr_in(v_addr_in), .valid_in(valid_in), .ready_out(ready_out),
        .adj_req_valid_out(adj_req_valid_out), .adj_req_addr_out(adj_req_addr_out),
        .adj_req_ready_in(adj_req_ready_in), .adj_resp_valid_in(adj_resp_valid_in),
        .adj_resp_data_in(adj_resp_data_in),
        .pos_req_valid_out(pos_req_valid_out), .pos_req_addr_out(pos_req_addr_out),
        .pos_req_ready_in(pos_req_ready_in), .pos_resp_valid_in(pos_resp_valid_in),
        .pos_resp_data_in(pos_resp_data_in),
        .vis_req_valid_out(vis_req_valid_out), .vis_req_addr_out(vis_req_addr_out),
        .vis_req_ready_in(vis_req_ready_in), .vis_resp_valid_in(vis_resp_valid_in),
        .vis_resp_hit_in(vis_resp_hit_in), .vis_set_out(vis_set_out),
        .vis_set_addr_out(vis_set_addr_out),
        .out_data_out(out_data_out), .out_first_out(out_first_out),
        .out_last_out(out_last_out), .out_valid_out(out_valid_out),
        .out_ready_in(out_ready_in),
        .done_out(done_out), .emitted_count_out(emitted_count_out),
        .skipped_count_out(skipped_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              first;
        logic              last;
    } word_t;

    word_t             exp_q[$];
    logic [ADDR_W-1:0] vis_q[$];
    logic [DATA_W-1:0] mem [MEMSZ];
    bit                vis_tab [MEMSZ];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int adj_hs = 0;
    int pos_hs = 0;
    int done_cnt = 0;
    int adj_resp_cyc = 0;
    int done_cyc = 0;
    int exp_emit = 0;
    int exp_skip = 0;
    int exp_adj = 0;
    int d0 = 0;
    int a0 = 0;
    bit hold_out = 1'b0;
    bit stale_mode = 1'b0;
    bit stale_fired = 1'b0;

    always @(posedge clk_in) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        n_vec++;
        n_err++;
        $display("[TB] FAIL %s", name);
    endtask

    // Reference model: walk the list, emit unvisited neighbours, stop at 0 or MAX_DEG entries.
    task automatic buildExpected(input logic [ADDR_W-1:0] v);
        bit vt [MEMSZ];
        logic [ADDR_W-1:0] p;
        logic [ADDR_W-1:0] e;
        int scanned;
        word_t w;
        vt = vis_tab;
        scanned = 0;
        exp_emit = 0;
        exp_skip = 0;
        exp_adj = 0;
        p = v + DIM + 1;
        forever begin
            e = mem[p[9:0]];
            exp_adj++;
            if (e == 0) break;
            p = p + 1;
            scanned++;
            if (vt[e[9:0]]) begin
                exp_skip++;
            end else begin
                vt[e[9:0]] = 1'b1;
                exp_emit++;
                vis_q.push_back(e);
                w.data = e; w.first = 1'b1; w.last = 1'b0;
                exp_q.push_back(w);
                for (int d = 0; d < DIM; d++) begin
                    p = e + 1 + d;
                    w.data = mem[p[9:0]]; w.first = 1'b0; w.last = (d == DIM - 1);
                    exp_q.push_back(w);
                end
                p = v + DIM + 1 + scanned;
            end
            if (MAX_DEG != 0 && scanned == MAX_DEG) break;
        end
    endtask

    // Adjacency memory port
    initial begin
        bit pend;
        int wt;
        logic [ADDR_W-1:0] pa;
        pend = 0; wt = 0; pa = '0;
        forever begin
            @(negedge clk_in);
            if (adj_req_valid_out && adj_req_ready_in) begin
                pend = 1; pa = adj_req_addr_out; wt = $urandom_range(0, 2); adj_hs++;
            end
            @(posedge clk_in); #1;
            adj_resp_valid_in = 1'b0;
            if (pend) begin
                if (wt == 0) begin
                    adj_resp_valid_in = 1'b1; adj_resp_data_in = mem[pa[9:0]];
                    pend = 0; adj_resp_cyc = cyc;
                end else wt--;
            end
            adj_req_ready_in = ($urandom_range(0, 3) != 0);
        end
    end

    // Position memory port
    initial begin
        bit pend;
        int wt;
        logic [ADDR_W-1:0] pa;
        pend = 0; wt = 0; pa = '0;
        forever begin
            @(negedge clk_in);
            if (pos_req_valid_out && pos_req_ready_in) begin
                pend = 1; pa = pos_req_addr_out; pos_hs++;
                wt = stale_mode ? 2 : $urandom_range(0, 2);
            end
            @(posedge clk_in); #1;
            pos_resp_valid_in = 1'b0;
            if (pend) begin
                if (wt == 0) begin
                    pos_resp_valid_in = 1'b1; pos_resp_data_in = mem[pa[9:0]]; pend = 0;
                    if (stale_mode) stale_fired = 1'b1;
                end else wt--;
            end
            pos_req_ready_in = ($urandom_range(0, 3) != 0);
        end
    end

    // Visited-table port
    initial begin
        bit pend;
        int wt;
        logic [ADDR_W-1:0] pa;
        pend = 0; wt = 0; pa = '0;
        forever begin
            @(negedge clk_in);
            if (vis_req_valid_out && vis_req_ready_in) begin
                pend = 1; pa = vis_req_addr_out; wt = $urandom_range(0, 2);
            end
            @(posedge clk_in); #1;
            vis_resp_valid_in = 1'b0;
            if (pend) begin
                if (wt == 0) begin
                    vis_resp_valid_in = 1'b1; vis_resp_hit_in = vis_tab[pa[9:0]]; pend = 0;
                end else wt--;
            end
            vis_req_ready_in = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk_in); #1;
            out_ready_in = hold_out ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Output stream monitor
    always @(negedge clk_in) begin
        word_t w;
        if (!rst_in && out_valid_out && out_ready_in) begin
            if (exp_q.size() == 0) begin
                failNow("out_unexpected_word");
            end else begin
                w = exp_q.pop_front();
                checkOutput("out_word", {out_data_out, out_first_out, out_last_out}, w);
            end
        end
    end

    // vis_set monitor also keeps the visited table current
    always @(negedge clk_in) begin
        if (!rst_in && vis_set_out) begin
            vis_tab[vis_set_addr_out[9:0]] = 1'b1;
            if (vis_q.size() == 0) failNow("vis_set_unexpected");
            else checkOutput("vis_set_addr", vis_set_addr_out, vis_q.pop_front());
        end
        if (!rst_in && done_out) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic startVertex(input logic [ADDR_W-1:0] v);
        buildExpected(v);
        @(posedge clk_in); #2;
        checkOutput("ready_idle", ready_out, 1);
        d0 = done_cnt;
        a0 = adj_hs;
        valid_in = 1'b1;
        v_addr_in = v;
        @(posedge clk_in); #2;
        valid_in = 1'b0;
        v_addr_in = $urandom;
    endtask

    task automatic finishVertex();
        int b;
        b = 0;
        while (done_cnt == d0 && b < 3000) begin @(posedge clk_in); b++; end
        if (done_cnt == d0) begin
            failNow("done_timeout");
        end else begin
            repeat (3) @(posedge clk_in);
            #2;
            checkOutput("done_pulses", done_cnt - d0, 1);
            checkOutput("emitted_count", emitted_count_out, exp_emit);
            checkOutput("skipped_count", skipped_count_out, exp_skip);
            checkOutput("adj_reads", adj_hs - a0, exp_adj);
            checkOutput("ready_after_done", ready_out, 1);
        end
        b = 0;
        while (exp_q.size() != 0 && b < 1000) begin @(posedge clk_in); b++; end
        checkOutput("drain_left", exp_q.size(), 0);
        checkOutput("vis_set_left", vis_q.size(), 0);
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] v);
        startVertex(v);
        finishVertex();
    endtask

    task automatic clearVisited();
        foreach (vis_tab[i]) vis_tab[i] = 1'b0;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [ADDR_W-1:0] v;
        logic [ADDR_W-1:0] nb;
        int len;
        int p0;
        int b;
        for (int i = 0; i < MEMSZ; i++) mem[i] = $urandom;
        clearVisited();

        repeat (3) @(posedge clk_in);
        #2;
        checkOutput("rst_ready", ready_out, 1);
        checkOutput("rst_out_valid", out_valid_out, 0);
        checkOutput("rst_req_valids", {adj_req_valid_out, pos_req_valid_out, vis_req_valid_out}, 0);
        checkOutput("rst_pulses", {vis_set_out, done_out}, 0);
        checkOutput("rst_counters", {emitted_count_out, skipped_count_out}, 0);
        rst_in = 1'b0;

        // Two unvisited neighbours
        mem[103] = 200; mem[104] = 300; mem[105] = 0;
        applyStimulus(100);

        // 200 already visited
        clearVisited();
        vis_tab[200] = 1'b1;
        applyStimulus(100);

        // Empty list: done two cycles after the adjacency response
        mem[183] = 0;
        applyStimulus(180);
        checkOutput("empty_done_latency", done_cyc - adj_resp_cyc, 2);

        // Entry limit: only MAX_DEG entries read
        clearVisited();
        mem[143] = 210; mem[144] = 220; mem[145] = 230; mem[146] = 240; mem[147] = 0;
        applyStimulus(140);

        // Backpressure: one packet buffered, FSM waits for room without position reads
        clearVisited();
        mem[123] = 200; mem[124] = 300; mem[125] = 260; mem[126] = 0;
        hold_out = 1'b1;
        @(posedge clk_in);
        p0 = pos_hs;
        startVertex(120);
        repeat (150) @(posedge clk_in);
        #2;
        checkOutput("bp_pos_reads", pos_hs - p0, DIM);
        checkOutput("bp_out_valid", out_valid_out, 1);
        checkOutput("bp_no_done", done_cnt - d0, 0);
        checkOutput("bp_pos_idle", pos_req_valid_out, 0);
        hold_out = 1'b0;
        finishVertex();

        // Randomized lists
        for (int it = 0; it < 30; it++) begin
            v = 400 + 16 * (it % 6);
            len = $urandom_range(0, 5);
            clearVisited();
            for (int j = 0; j < len; j++) begin
                nb = 512 + 4 * $urandom_range(0, 15);
                mem[v + 3 + j] = nb;
                if ($urandom_range(0, 3) == 0) vis_tab[nb[9:0]] = 1'b1;
            end
            mem[v + 3 + len] = 0;
            applyStimulus(v);
        end

        // Reset while a position read is outstanding; its late response must be dropped
        clearVisited();
        hold_out = 1'b1;
        stale_mode = 1'b1;
        stale_fired = 1'b0;
        @(posedge clk_in);
        startVertex(100);
        b = 0;
        @(negedge clk_in);
        while (!(pos_req_valid_out && pos_req_ready_in) && b < 500) begin
            @(negedge clk_in); b++;
        end
        if (b >= 500) failNow("rst_pos_handshake_timeout");
        @(posedge clk_in); #2;
        rst_in = 1'b1;
        @(posedge clk_in); #2;
        rst_in = 1'b0;
        exp_q.delete();
        vis_q.delete();
        checkOutput("midrst_out_valid", out_valid_out, 0);
        checkOutput("midrst_ready", ready_out, 1);
        checkOutput("midrst_counters", {emitted_count_out, skipped_count_out}, 0);
        repeat (5) @(posedge clk_in);
        #2;
        checkOutput("stale_resp_sent", stale_fired, 1);
        checkOutput("stale_no_push", out_valid_out, 0);
        checkOutput("stale_state", {ready_out, pos_req_valid_out}, 2'b10);
        stale_mode = 1'b0;
        hold_out = 1'b0;
        clearVisited();
        applyStimulus(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
